// File: rtl/ibex_mprf_msg_loader.sv
// MPRF message loader: sequences a word stream into MPRF writes.
// Optional collision retry: IBEX_MPRF_LOADER_COLLISION_RETRY_EN.
module ibex_mprf_msg_loader #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [4:0]           cmd_base_i,
  input  logic [1:0]           cmd_len_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 msg_valid_o,
  output logic [4:0]           msg_addr_o,
  output logic [DataWidth-1:0] msg_data_o,
  output logic [1:0]           msg_len_o,
  input  logic                 core_mprf_we_i,
  input  logic [4:0]           core_waddr_i,
  output logic                 busy_o,
  output logic                 msg_done_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [4:0]           base_q, base_d;
  logic [1:0]           len_q, len_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic [4:0]           addr_q, addr_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;

  logic                 collision;
  logic                 accept;
  logic [4:0]           addr_raw;
  logic [4:0]           next_addr;

`ifdef IBEX_MPRF_LOADER_COLLISION_RETRY_EN
  assign collision = valid_q & core_mprf_we_i &
                     (core_waddr_i == addr_q);
`else
  // Core wins silently; the loader never observes it.
  logic unused_core;
  assign unused_core = ^{core_mprf_we_i, core_waddr_i};
  assign collision   = 1'b0;
`endif

  assign addr_raw  = base_q + {3'b000, cnt_q[1:0]};
  assign next_addr = RV32E ? {1'b0, addr_raw[3:0]} : addr_raw;

  assign cmd_ready_o  = (state_q == IDLE);
  assign data_ready_o = (state_q == LOAD) &
                        (cnt_q <= {1'b0, len_q}) &
                        ~collision;
  assign accept       = data_valid_i & data_ready_o;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          base_d  = cmd_base_i;
          len_d   = cmd_len_i;
          cnt_d   = 3'd0;
          last_d  = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (collision) begin
          valid_d = 1'b1;
        end else if (accept) begin
          valid_d = 1'b1;
          addr_d  = next_addr;
          data_d  = data_i;
          cnt_d   = cnt_q + 3'd1;
          last_d  = (cnt_q[1:0] == len_q);
        end
        if (valid_q && !collision && last_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      cnt_d   = 3'd0;
      last_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign msg_valid_o = valid_q;
  assign msg_addr_o  = addr_q;
  assign msg_data_o  = data_q;
  assign msg_len_o   = len_q;
  assign msg_done_o  = done_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_mprf_msg_loader.sv
// Directed bench for ibex_mprf_msg_loader (RV32E=0 and RV32E=1).
// Collision expectations follow IBEX_MPRF_LOADER_COLLISION_RETRY_EN.
module tb_ibex_mprf_msg_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [4:0]  cmd_base = '0;
  logic [1:0]  cmd_len = '0;
  logic        data_valid = 1'b0;
  logic [31:0] data = '0;
  logic        core_we = 1'b0;
  logic [4:0]  core_waddr = '0;

  logic        cmd_ready, data_ready, m_valid, busy, done;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_len;

  logic        cmd_ready2, data_ready2, m_valid2, busy2, done2;
  logic [4:0]  m_addr2;
  logic [31:0] m_data2;
  logic [1:0]  m_len2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ibex_mprf_msg_loader #(.RV32E(1'b0), .DataWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_base_i(cmd_base), .cmd_len_i(cmd_len),
    .data_valid_i(data_valid), .data_ready_o(data_ready),
    .data_i(data), .msg_valid_o(m_valid), .msg_addr_o(m_addr),
    .msg_data_o(m_data), .msg_len_o(m_len),
    .core_mprf_we_i(core_we), .core_waddr_i(core_waddr),
    .busy_o(busy), .msg_done_o(done)
  );

  ibex_mprf_msg_loader #(.RV32E(1'b1), .DataWidth(32)) dut_e (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready2),
    .cmd_base_i(cmd_base), .cmd_len_i(cmd_len),
    .data_valid_i(data_valid), .data_ready_o(data_ready2),
    .data_i(data), .msg_valid_o(m_valid2), .msg_addr_o(m_addr2),
    .msg_data_o(m_data2), .msg_len_o(m_len2),
    .core_mprf_we_i(core_we), .core_waddr_i(core_waddr),
    .busy_o(busy2), .msg_done_o(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [4:0] b, input logic [1:0] l);
    cmd_valid = 1'b1;
    cmd_base  = b;
    cmd_len   = l;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("cmd_ready_load", cmd_ready, 0);
    chk("len_latched", m_len, l);
    chk("busy_load", busy, 1);
  endtask

  task automatic run_msg(input logic [4:0] b, input logic [1:0] l,
                         input logic [19:0] ea, input logic [19:0] eb,
                         input logic [31:0] seed);
    send_cmd(b, l);
    data_valid = 1'b1;
    data = seed;
    for (int i = 0; i <= int'(l); i++) begin
      tick();
      if (i < int'(l)) data = seed + i + 1;
      else data_valid = 1'b0;
      #1;
      chk("wr_valid", m_valid, 1);
      chk("wr_addr", m_addr, ea[5*i +: 5]);
      chk("wr_data", m_data, seed + i);
      chk("wr_addr_e", m_addr2, eb[5*i +: 5]);
      chk("wr_valid_e", m_valid2, 1);
    end
    chk("no_early_done", done, 0);
    chk("ready_after_last", data_ready, 0);
    tick();
    chk("done_pulse", done, 1);
    chk("done_pulse_e", done2, 1);
    chk("done_busy", busy, 1);
    chk("done_cmd_ready", cmd_ready, 0);
    chk("valid_drop", m_valid, 0);
    tick();
    chk("done_once", done, 0);
    tick();
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_data", m_data, 0);
    chk("rst_len", m_len, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_data_ready", data_ready, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Data offered while idle must be ignored.
    data_valid = 1'b1;
    data = 32'h1111_1111;
    #1;
    chk("idle_no_ready", data_ready, 0);
    tick();
    chk("idle_no_write", m_valid, 0);
    data_valid = 1'b0;

    // Base 4, len 3.
    run_msg(5'd4, 2'd3, {5'd7, 5'd6, 5'd5, 5'd4},
            {5'd7, 5'd6, 5'd5, 5'd4}, 32'hA0);

    // Wrap: base 30 (RV32E masks it to 14).
    run_msg(5'd30, 2'd3, {5'd1, 5'd0, 5'd31, 5'd30},
            {5'd1, 5'd0, 5'd15, 5'd14}, 32'h30);
    run_msg(5'd14, 2'd3, {5'd17, 5'd16, 5'd15, 5'd14},
            {5'd1, 5'd0, 5'd15, 5'd14}, 32'h14);

    // Single word after a 3-cycle gap.
    send_cmd(5'd9, 2'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("gap_ready", data_ready, 1);
      tick();
      chk("gap_no_valid", m_valid, 0);
    end
    data_valid = 1'b1;
    data = 32'hDEADBEEF;
    tick();
    data_valid = 1'b0;
    #1;
    chk("single_valid", m_valid, 1);
    chk("single_addr", m_addr, 9);
    chk("single_data", m_data, 32'hDEADBEEF);
    chk("single_ready", data_ready, 0);
    tick();
    chk("single_once", m_valid, 0);
    chk("single_done", done, 1);
    tick();
    chk("single_done_once", done, 0);
    tick();
    chk("single_idle", cmd_ready, 1);

    // Core write to the same register as the loader.
    send_cmd(5'd4, 2'd3);
    data_valid = 1'b1;
    data = 32'hB0;
    tick();
    data = 32'hB1;
    chk("col_w0_addr", m_addr, 4);
    tick();
    chk("col_w1_addr", m_addr, 5);
    chk("col_w1_data", m_data, 32'hB1);
    core_we = 1'b1;
    core_waddr = 5'd5;
    data = 32'hB2;
    #1;
`ifdef IBEX_MPRF_LOADER_COLLISION_RETRY_EN
    chk("col_ready_low", data_ready, 0);
    tick();
    core_we = 1'b0;
    #1;
    chk("col_hold_valid", m_valid, 1);
    chk("col_hold_addr", m_addr, 5);
    chk("col_hold_data", m_data, 32'hB1);
    chk("col_hold_ready", data_ready, 1);
    tick();
    data = 32'hB3;
    chk("col_w2_addr", m_addr, 6);
    chk("col_w2_data", m_data, 32'hB2);
    tick();
    data_valid = 1'b0;
    chk("col_w3_addr", m_addr, 7);
    chk("col_w3_data", m_data, 32'hB3);
    chk("col_done_late", done, 0);
    tick();
    chk("col_done", done, 1);
`else
    chk("col_ready_high", data_ready, 1);
    tick();
    core_we = 1'b0;
    data = 32'hB3;
    chk("col_w2_addr", m_addr, 6);
    chk("col_w2_data", m_data, 32'hB2);
    tick();
    data_valid = 1'b0;
    chk("col_w3_addr", m_addr, 7);
    chk("col_w3_data", m_data, 32'hB3);
    tick();
    chk("col_done", done, 1);
`endif
    tick();
    tick();
    chk("col_idle", cmd_ready, 1);

    // Flush after two of four words.
    send_cmd(5'd20, 2'd3);
    data_valid = 1'b1;
    data = 32'hC0;
    tick();
    data = 32'hC1;
    tick();
    chk("fl_w1_addr", m_addr, 21);
    data_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("fl_valid", m_valid, 0);
    chk("fl_cmd_ready", cmd_ready, 1);
    chk("fl_busy", busy, 0);
    chk("fl_done", done, 0);
    tick();
    chk("fl_no_done", done, 0);
    run_msg(5'd0, 2'd1, {10'd0, 5'd1, 5'd0},
            {10'd0, 5'd1, 5'd0}, 32'hF0);

    // Asynchronous reset mid-message.
    send_cmd(5'd12, 2'd3);
    data_valid = 1'b1;
    data = 32'hD0;
    tick();
    data = 32'hD1;
    tick();
    chk("rm_pre_addr", m_addr, 13);
    rst_n = 1'b0;
    data_valid = 1'b0;
    #1;
    chk("rm_valid", m_valid, 0);
    chk("rm_addr", m_addr, 0);
    chk("rm_data", m_data, 0);
    chk("rm_len", m_len, 0);
    chk("rm_busy", busy, 0);
    chk("rm_done", done, 0);
    chk("rm_cmd_ready", cmd_ready, 1);
    chk("rm_data_ready", data_ready, 0);
    chk("rm_busy_e", busy2, 0);
    chk("rm_len_e", m_len2, 0);
    tick();
    chk("rm_hold_valid", m_valid, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("rr_cmd_ready", cmd_ready, 1);
    chk("rr_data_ready", data_ready, 0);
    chk("rr_cmd_ready_e", cmd_ready2, 1);
    chk("rr_data_ready_e", data_ready2, 0);
    tick();
    chk("rr_no_done", done, 0);
    chk("rr_no_valid", m_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
